// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline: ALU opcodes, width defaults and the
// EX-stage FSM encoding.
package pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int MUL_STEPS  = 32;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_MUL = 4'd8
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_mul.sv
// Iterative shift-add multiplier: one partial-product step per clock,
// MUL_STEPS steps; done/product are valid combinationally on the last step.
module ex_mul
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kill,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic              r_busy;
    logic [5:0]        r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_step;

    assign w_step  = r_acc + (r_b[0] ? r_a : '0);
    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == 6'(MUL_STEPS - 1));
    // The final step's sum is handed out directly so the stage can load it
    // on the same edge the step completes.
    assign product = w_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc <= w_step;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 6'd1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM output register. Define EX_MUL_EN to build the
// multi-cycle multiplier path (BUSY state, stall); otherwise MUL yields 0.
module ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              no_clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic              branch_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic [4:0]        rd_in,
    output logic              stall,
    output logic              valid_out,
    output logic              branch,
    output logic              zero,
    output logic              mem_write,
    output logic              reg_write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data,
    output logic [4:0]        rd
);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic              w_slt;
    logic              w_load_alu;

    logic              r_valid;
    logic              r_branch;
    logic              r_zero;
    logic              r_mem_write;
    logic              r_reg_write;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_wdata;
    logic [4:0]        r_rd;

    assign w_b   = alu_src ? imm : operand_b;
    assign w_slt = $signed(operand_a) < $signed(w_b);

    always_comb begin
        w_alu = '0;
        case (alu_op)
            OP_ADD:  w_alu = operand_a + w_b;
            OP_SUB:  w_alu = operand_a - w_b;
            OP_AND:  w_alu = operand_a & w_b;
            OP_OR:   w_alu = operand_a | w_b;
            OP_XOR:  w_alu = operand_a ^ w_b;
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, w_slt};
            OP_SLL:  w_alu = operand_a << w_b[4:0];
            OP_SRL:  w_alu = operand_a >> w_b[4:0];
            default: w_alu = '0;
        endcase
    end

`ifdef EX_MUL_EN
    ex_state_e         r_state;
    ex_state_e         w_state_nxt;
    logic              w_accept_mul;
    logic              w_load_mul;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;

    logic              r_cap_branch;
    logic              r_cap_mem_write;
    logic              r_cap_reg_write;
    logic [4:0]        r_cap_rd;
    logic [DATA_W-1:0] r_cap_wdata;

    always_ff @(posedge no_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!flush && valid_in && alu_op == OP_MUL) w_state_nxt = ST_BUSY;
            ST_BUSY: if (flush || w_mul_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // flush outranks everything: nothing is accepted or completed that cycle.
    always_comb begin
        w_accept_mul = 1'b0;
        w_load_alu   = 1'b0;
        w_load_mul   = 1'b0;
        if (!flush) begin
            if (r_state == ST_IDLE) begin
                if (valid_in && alu_op == OP_MUL) begin
                    w_accept_mul = 1'b1;
                end else if (valid_in) begin
                    w_load_alu = 1'b1;
                end
            end else if (w_mul_busy && w_mul_done) begin
                w_load_mul = 1'b1;
            end
        end
    end

    assign stall = (r_state == ST_BUSY);

    ex_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (no_clk),
        .rst_n   (rst_n),
        .kill    (flush),
        .start   (w_accept_mul),
        .a       (operand_a),
        .b       (w_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    always_ff @(posedge no_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_branch    <= 1'b0;
            r_cap_mem_write <= 1'b0;
            r_cap_reg_write <= 1'b0;
            r_cap_rd        <= '0;
            r_cap_wdata     <= '0;
        end else if (w_accept_mul) begin
            r_cap_branch    <= branch_in;
            r_cap_mem_write <= mem_write_in;
            r_cap_reg_write <= reg_write_in;
            r_cap_rd        <= rd_in;
            r_cap_wdata     <= operand_b;
        end
    end
`else
    assign w_load_alu = !flush && valid_in;
    assign stall      = 1'b0;
`endif

    // Anything not loaded as a live result becomes an all-zero bubble.
    always_ff @(posedge no_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_branch    <= 1'b0;
            r_zero      <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
            r_result    <= '0;
            r_wdata     <= '0;
            r_rd        <= '0;
        end else if (w_load_alu) begin
            r_valid     <= 1'b1;
            r_branch    <= branch_in;
            r_zero      <= (w_alu == '0);
            r_mem_write <= mem_write_in;
            r_reg_write <= reg_write_in;
            r_result    <= w_alu;
            r_wdata     <= operand_b;
            r_rd        <= rd_in;
`ifdef EX_MUL_EN
        end else if (w_load_mul) begin
            r_valid     <= 1'b1;
            r_branch    <= r_cap_branch;
            r_zero      <= (w_product == '0);
            r_mem_write <= r_cap_mem_write;
            r_reg_write <= r_cap_reg_write;
            r_result    <= w_product;
            r_wdata     <= r_cap_wdata;
            r_rd        <= r_cap_rd;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_branch    <= 1'b0;
            r_zero      <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
            r_result    <= '0;
            r_wdata     <= '0;
            r_rd        <= '0;
        end
    end

    assign valid_out  = r_valid;
    assign branch     = r_branch;
    assign zero       = r_zero;
    assign mem_write  = r_mem_write;
    assign reg_write  = r_reg_write;
    assign alu_result = r_result;
    assign write_data = r_wdata;
    assign rd         = r_rd;
    assign address    = r_result[ADDR_W-1:0];

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus random traffic
// compared against a cycle-level behavioural model. Honours EX_MUL_EN.
module tb_ex_stage;

    localparam int DW = 32;
    localparam int AW = 10;
`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          no_clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          valid_in;
    logic [3:0]    alu_op;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic [DW-1:0] imm;
    logic          alu_src;
    logic          branch_in;
    logic          mem_write_in;
    logic          reg_write_in;
    logic [4:0]    rd_in;
    logic          stall;
    logic          valid_out;
    logic          branch;
    logic          zero;
    logic          mem_write;
    logic          reg_write;
    logic [AW-1:0] address;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] write_data;
    logic [4:0]    rd;

    ex_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .no_clk       (no_clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .valid_in     (valid_in),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .imm          (imm),
        .alu_src      (alu_src),
        .branch_in    (branch_in),
        .mem_write_in (mem_write_in),
        .reg_write_in (reg_write_in),
        .rd_in        (rd_in),
        .stall        (stall),
        .valid_out    (valid_out),
        .branch       (branch),
        .zero         (zero),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .address      (address),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .rd           (rd)
    );

    // ---------------- clock ----------------
    always #5 no_clk = ~no_clk;

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_valid, m_br, m_mw, m_rw;
    logic [DW-1:0] m_res, m_wd;
    logic [4:0]    m_rd;
    int            m_left;
    logic [DW-1:0] exp_q[$];
    logic          p_br, p_mw, p_rw;
    logic [DW-1:0] p_wd;
    logic [4:0]    p_rd;

    function automatic logic [DW-1:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 1 : 0;
            6: return a << sh;
            7: return a >> sh;
            default: return '0;
        endcase
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_br = 0; m_mw = 0; m_rw = 0;
        m_res = '0; m_wd = '0; m_rd = '0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_left = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [DW-1:0] b;
        b = alu_src ? imm : operand_b;
        if (flush) begin
            model_bubble();
            m_left = 0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
            model_bubble();
            if (m_left == 0) begin
                m_valid = 1;
                m_res = exp_q.pop_front();
                m_wd = p_wd; m_rd = p_rd; m_br = p_br; m_mw = p_mw; m_rw = p_rw;
            end
        end else if (valid_in && int'(alu_op) == 8 && MUL_EN) begin
            model_bubble();
            exp_q.push_back(operand_a * b);
            p_wd = operand_b; p_rd = rd_in; p_br = branch_in; p_mw = mem_write_in; p_rw = reg_write_in;
            m_left = 32;
        end else if (valid_in) begin
            m_valid = 1;
            m_res = ref_alu(int'(alu_op), operand_a, b);
            m_wd = operand_b; m_rd = rd_in; m_br = branch_in; m_mw = mem_write_in; m_rw = reg_write_in;
        end else begin
            model_bubble();
        end
    endtask

    task automatic compare_model();
        check_eq("stall", stall, m_left > 0);
        check_eq("valid_out", valid_out, m_valid);
        if (m_valid) begin
            check_eq("alu_result", alu_result, m_res);
            check_eq("zero", zero, m_res == '0);
            check_eq("address", address, m_res[AW-1:0]);
            check_eq("write_data", write_data, m_wd);
            check_eq("rd", rd, m_rd);
            check_eq("branch", branch, m_br);
            check_eq("mem_write", mem_write, m_mw);
            check_eq("reg_write", reg_write, m_rw);
        end else begin
            check_eq("bubble_branch", branch, 1'b0);
            check_eq("bubble_mem_write", mem_write, 1'b0);
            check_eq("bubble_reg_write", reg_write, 1'b0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] im, input bit src, input bit v, input bit br,
                         input bit mw, input bit rw, input int rdv, input bit fl);
        alu_op = 4'(op); operand_a = a; operand_b = b; imm = im; alu_src = src;
        valid_in = v; branch_in = br; mem_write_in = mw; reg_write_in = rw;
        rd_in = 5'(rdv); flush = fl;
    endtask

    task automatic drive_random(input bit allow_flush);
        logic [DW-1:0] a, b, im;
        int mode;
        a = $urandom;
        mode = $urandom_range(0, 3);
        b = (mode == 0) ? a : (mode == 1) ? DW'($urandom_range(0, 40)) : $urandom;
        im = ($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 40));
        drive($urandom_range(0, 15), a, b, im, 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 31),
              allow_flush && ($urandom_range(0, 19) == 0));
    endtask

    task automatic cycle();
        model_step();
        @(posedge no_clk);
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, valid_out, 1'b0);
        check_eq({tag, "_stall"}, stall, 1'b0);
        check_eq({tag, "_result"}, alu_result, '0);
        check_eq({tag, "_zero"}, zero, 1'b0);
        check_eq({tag, "_ctrl"}, {branch, mem_write, reg_write}, 3'b000);
        check_eq({tag, "_wdata"}, write_data, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int stall_n;
        int seen_valid;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_all_zero("reset");
        #8;
        rst_n = 1'b1;
        model_reset();

        // ADD 7+5
        drive(0, 7, 5, 0, 0, 1, 0, 0, 1, 3, 0);
        cycle();
        check_eq("add_result", alu_result, 12);
        check_eq("add_zero", zero, 1'b0);
        check_eq("add_address", address, 12);
        check_eq("add_valid", valid_out, 1'b1);

        // SUB 9-9 with branch
        drive(1, 9, 9, 0, 0, 1, 1, 0, 0, 0, 0);
        cycle();
        check_eq("sub_branch", branch, 1'b1);
        check_eq("sub_zero", zero, 1'b1);

        // store address calculation using the immediate
        drive(0, 32'h401, 32'hAB, 32'h3FF, 1, 1, 0, 1, 0, 0, 0);
        cycle();
        check_eq("sw_result", alu_result, 32'h800);
        check_eq("sw_address", address, 10'h000);
        check_eq("sw_write_data", write_data, 32'hAB);
        check_eq("sw_mem_write", mem_write, 1'b1);

        // idle bubble
        drive(0, 1, 2, 0, 0, 0, 1, 1, 1, 5, 0);
        cycle();
        check_eq("idle_valid", valid_out, 1'b0);

        // multiply
        drive(8, 32'h0001_0003, 32'h0000_0010, 0, 0, 1, 0, 0, 1, 9, 0);
        cycle();
`ifdef EX_MUL_EN
        stall_n = stall ? 1 : 0;
        for (int i = 1; i <= 32; i++) begin
            drive_random(1'b0);
            cycle();
            if (stall) stall_n++;
        end
        check_eq("mul_stall_cycles", stall_n, 32);
        check_eq("mul_result", alu_result, 32'h0010_0030);
        check_eq("mul_valid", valid_out, 1'b1);
        check_eq("mul_rd", rd, 9);
`else
        check_eq("mul_off_result", alu_result, '0);
        check_eq("mul_off_valid", valid_out, 1'b1);
        check_eq("mul_off_stall", stall, 1'b0);
`endif

        // flush mid-multiply (or flush beating a valid op)
`ifdef EX_MUL_EN
        drive(8, 32'h1234, 32'h77, 0, 0, 1, 1, 1, 1, 4, 0);
        cycle();
        for (int i = 1; i < 10; i++) begin
            drive_random(1'b0);
            cycle();
        end
        drive(0, 3, 4, 0, 0, 1, 1, 1, 1, 2, 1);
        cycle();
        check_eq("flush_stall", stall, 1'b0);
        check_eq("flush_valid", valid_out, 1'b0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
            if (valid_out) seen_valid++;
        end
        check_eq("flush_no_product", seen_valid, 0);
`else
        drive(0, 3, 4, 0, 0, 1, 1, 1, 1, 2, 1);
        cycle();
        check_eq("flush_valid", valid_out, 1'b0);
        check_eq("flush_ctrl", {branch, mem_write, reg_write}, 3'b000);
`endif

        // asynchronous reset between edges, mid-operation
        drive(8, 32'hFFFF, 32'h3, 0, 0, 1, 1, 1, 1, 7, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive_random(1'b0);
            cycle();
        end
        drive(0, 5, 5, 0, 0, 1, 1, 1, 1, 1, 0);
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        rst_n = 1'b1;
        model_reset();
        drive(0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0);
        cycle();
        check_eq("post_reset_add", alu_result, 2);
        check_eq("post_reset_valid", valid_out, 1'b1);

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            drive_random(1'b1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
